iic_reg_arbiter: RTL and testbench
==================================

IIC_REG_ARBITER -- requirements
Module: iic_reg_arbiter

Interface
REQ-001 SHALL take parameters: AW, default 8, memory address width; DW, fixed at 8, data width.
REQ-002 SHALL have ports, in order:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- iic_address  in  AW  IIC-slave bus address.
- iic_writedata  in  8  IIC-slave write data.
- iic_write  in  1  single-cycle IIC write strobe.
- iic_read  in  1  single-cycle IIC read strobe.
- iic_readdata  out  8  read data returned to the IIC slave.
- h_valid  in  1  host request valid.
- h_we  in  1  host request type: 1 = write, 0 = read.
- h_address  in  AW  host address.
- h_writedata  in  8  host write data.
- h_ready  out  1  host request accepted when h_valid & h_ready.
- h_rvalid  out  1  host read data valid, single cycle.
- h_readdata  out  8  host read data.
- mem_address  out  AW  single-port memory address.
- mem_writedata  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_readdata  in  8  memory read data, valid the cycle after mem_re.
- conflict_cnt  out  16  saturating count of cycles where an IIC strobe blocked a pending host request.

Function
REQ-003 The IIC port SHALL have absolute priority. iic_write or iic_read SHALL drive the mem_* outputs combinationally in the same cycle, with zero added latency.
REQ-004 In the cycle after an IIC read, iic_readdata SHALL equal mem_readdata combinationally. It SHALL then hold that value in a register until the next IIC read completes.
REQ-005 If iic_write and iic_read are both asserted, the SHALL perform only the write; no read SHALL be issued.
REQ-006 The host side SHALL use a one-entry request buffer with states EMPTY and FULL. h_ready SHALL equal (state == EMPTY), driven from a register.
REQ-007 EMPTY -> FULL on h_valid & h_ready, latching h_we, h_address and h_writedata.
REQ-008 FULL with no IIC strobe: the buffer SHALL issue to the memory (mem_we = buffered we, mem_re = ~we) and go to EMPTY next cycle.
REQ-009 FULL with an IIC strobe: the buffer SHALL stay FULL and increment conflict_cnt by 1, saturating at 16'hFFFF.
REQ-010 For a host read issued in cycle t: h_rvalid = 1 and h_readdata = mem_readdata in cycle t+1. h_readdata SHALL hold its value thereafter.
REQ-011 Best-case host throughput SHALL be one request per 2 cycles: accept, then issue. There SHALL be no back-to-back accept.
REQ-012 When no request is active, the mem_* outputs SHALL be: mem_we = mem_re = 0, mem_address and mem_writedata = 0.
REQ-013 A host read and an IIC read SHALL never overlap in the same cycle. The read-return source SHALL be tracked by a 1-bit register, rd_src, to steer mem_readdata.
REQ-014 The IIC slave issues at most one strobe per SCL bit. The block SHALL NOT rely on this; consecutive IIC strobes SHALL each be served, and the host SHALL wait.

Reset
REQ-015 While rst is asserted, the block SHALL set:
- buffer state EMPTY; h_ready = 0 during rst and 1 in the first cycle after.
- h_rvalid = 0.
- conflict_cnt = 0.
- iic_readdata = 0 and h_readdata = 0.
- rd_src cleared.
REQ-016 A host read issued in the cycle rst asserts SHALL NOT produce h_rvalid.
REQ-017 IIC strobes during rst SHALL still drive the mem_* outputs combinationally; no read-return registers SHALL update.

Verification
REQ-018 IIC read: iic_read = 1, iic_address = 8'h10, with mem[8'h10] = 8'hA5. Required: mem_re = 1 in the same cycle; iic_readdata = 8'hA5 the next cycle, held afterwards.
REQ-019 Host write: h_valid = 1, h_we = 1, address 8'h20, data 8'h3C, no IIC activity. Required: h_ready = 1 at accept; mem_we = 1 with 8'h20/8'h3C exactly one cycle later; h_ready = 1 again the cycle after.
REQ-020 Collision: host read of 8'h05 buffered, then IIC writes strobed on three consecutive cycles. Required: IIC writes performed in those three cycles; host read issued in the 4th cycle; h_rvalid in the 5th; conflict_cnt = 3.
REQ-021 Simultaneous IIC strobes: iic_write = iic_read = 1. Required: mem_we = 1, mem_re = 0; iic_readdata unchanged.
REQ-022 Saturation: 70000 blocked cycles. Required: conflict_cnt = 16'hFFFF and stays there.
REQ-023 Reset mid-operation: rst asserted in the cycle a host read issues. Required: h_rvalid = 0 next cycle; buffer EMPTY; conflict_cnt = 0.

Source files
------------

// File: rtl/iic_reg_arbiter.sv
// Arbitrates one single-port memory between an IIC slave (absolute priority,
// zero latency) and a host port with a one-entry request buffer.
module iic_reg_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] iic_address,
    input  logic [DW-1:0] iic_writedata,
    input  logic          iic_write,
    input  logic          iic_read,
    output logic [DW-1:0] iic_readdata,
    input  logic          h_valid,
    input  logic          h_we,
    input  logic [AW-1:0] h_address,
    input  logic [DW-1:0] h_writedata,
    output logic          h_ready,
    output logic          h_rvalid,
    output logic [DW-1:0] h_readdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writedata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_readdata,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    buf_state_e    state_q, state_d;
    logic          buf_we_q, buf_we_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [DW-1:0] buf_wd_q, buf_wd_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_src_q, rd_src_d;      // 1 = last read was the host's
    logic [DW-1:0] iic_rdata_q, iic_rdata_d;
    logic [DW-1:0] h_rdata_q, h_rdata_d;
    logic [15:0]   cnt_q, cnt_d;

    logic iic_act, accept, issue, iic_ret, h_ret;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            rd_pend_q   <= 1'b0;
            rd_src_q    <= 1'b0;
            iic_rdata_q <= '0;
            h_rdata_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rd_src_q    <= rd_src_d;
            iic_rdata_q <= iic_rdata_d;
            h_rdata_q   <= h_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: the buffer payload is only consumed while state_q == FULL, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_we_q   <= buf_we_d;
        buf_addr_q <= buf_addr_d;
        buf_wd_q   <= buf_wd_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d       = state_q;
        buf_we_d      = buf_we_q;
        buf_addr_d    = buf_addr_q;
        buf_wd_d      = buf_wd_q;
        rd_pend_d     = 1'b0;
        rd_src_d      = rd_src_q;
        cnt_d         = cnt_q;
        mem_address   = '0;
        mem_writedata = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;

        iic_act = iic_write | iic_read;
        h_ready = ~rst & (state_q == EMPTY);
        accept  = h_valid & h_ready;
        issue   = (state_q == FULL) & ~iic_act & ~rst;

        // Read data returns one cycle after mem_re; steer it to its requester.
        iic_ret      = rd_pend_q & ~rd_src_q;
        h_ret        = rd_pend_q & rd_src_q;
        iic_readdata = iic_ret ? mem_readdata : iic_rdata_q;
        h_readdata   = h_ret ? mem_readdata : h_rdata_q;
        h_rvalid     = h_ret;
        iic_rdata_d  = iic_readdata;
        h_rdata_d    = h_readdata;

        if (iic_write) begin
            mem_we        = 1'b1;
            mem_address   = iic_address;
            mem_writedata = iic_writedata;
        end else if (iic_read) begin
            mem_re      = 1'b1;
            mem_address = iic_address;
            rd_pend_d   = 1'b1;
            rd_src_d    = 1'b0;
        end else if (issue) begin
            mem_we        = buf_we_q;
            mem_re        = ~buf_we_q;
            mem_address   = buf_addr_q;
            mem_writedata = buf_we_q ? buf_wd_q : '0;
            rd_pend_d     = ~buf_we_q;
            rd_src_d      = ~buf_we_q ? 1'b1 : rd_src_q;
            state_d       = EMPTY;
        end

        if ((state_q == FULL) && iic_act && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;

        if (accept) begin
            state_d    = FULL;
            buf_we_d   = h_we;
            buf_addr_d = h_address;
            buf_wd_d   = h_writedata;
        end

        conflict_cnt = cnt_q;
    end

endmodule

// File: tb/tb_iic_reg_arbiter.sv
// Bench for iic_reg_arbiter: directed vector table, a saturation sequence and
// randomized traffic against a queue-based reference model.
module tb_iic_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] iic_address, iic_writedata, iic_readdata;
    logic       iic_write, iic_read;
    logic       h_valid, h_we, h_ready, h_rvalid;
    logic [7:0] h_address, h_writedata, h_readdata;
    logic [7:0] mem_address, mem_writedata, mem_readdata;
    logic       mem_we, mem_re;
    logic [15:0] conflict_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    iic_reg_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .iic_address(iic_address), .iic_writedata(iic_writedata),
        .iic_write(iic_write), .iic_read(iic_read), .iic_readdata(iic_readdata),
        .h_valid(h_valid), .h_we(h_we), .h_address(h_address),
        .h_writedata(h_writedata), .h_ready(h_ready), .h_rvalid(h_rvalid),
        .h_readdata(h_readdata), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_readdata(mem_readdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port memory with one-cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_writedata;
        if (mem_re) mem_readdata <= mem[mem_address];
    end

    // ---------------- reference model ----------------
    typedef struct { bit we; logic [7:0] addr; logic [7:0] wd; } hreq_t;
    typedef struct { bit host; logic [7:0] data; } ret_t;

    logic [7:0] ref_mem [256];
    hreq_t      pend[$];
    ret_t       rets[$];
    logic [7:0] m_iic_hold = 8'h00;
    logic [7:0] m_h_hold   = 8'h00;
    int         m_cnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        bit         iic_r, host_r;
        logic [7:0] e_ird, e_hrd;
        iic_r  = (rets.size() != 0) && !rets[0].host;
        host_r = (rets.size() != 0) && rets[0].host;
        e_ird  = iic_r  ? rets[0].data : m_iic_hold;
        e_hrd  = host_r ? rets[0].data : m_h_hold;
        check("m_h_ready", h_ready, !rst && (pend.size() == 0));
        check("m_h_rvalid", h_rvalid, host_r);
        check("m_h_readdata", h_readdata, e_hrd);
        check("m_iic_readdata", iic_readdata, e_ird);
        check("m_conflict_cnt", conflict_cnt, m_cnt);
        if (iic_write) begin
            check("m_mem_ctl", {mem_we, mem_re}, 2'b10);
            check("m_mem_addr", mem_address, iic_address);
            check("m_mem_wd", mem_writedata, iic_writedata);
        end else if (iic_read) begin
            check("m_mem_ctl", {mem_we, mem_re}, 2'b01);
            check("m_mem_addr", mem_address, iic_address);
        end else if (!rst) begin
            if (pend.size() != 0) begin
                check("m_mem_ctl", {mem_we, mem_re}, {pend[0].we, !pend[0].we});
                check("m_mem_addr", mem_address, pend[0].addr);
                check("m_mem_wd", mem_writedata, pend[0].we ? pend[0].wd : 8'h00);
            end else begin
                check("m_mem_idle", {mem_we, mem_re, mem_address, mem_writedata}, 18'h0);
            end
        end
    endtask

    task automatic model_update();
        bit    was_empty;
        ret_t  r;
        hreq_t q;
        was_empty = (pend.size() == 0);
        if (rst) begin
            if (iic_write) ref_mem[iic_address] = iic_writedata;
            pend.delete();
            rets.delete();
            m_iic_hold = 8'h00;
            m_h_hold   = 8'h00;
            m_cnt      = 0;
        end else begin
            if (rets.size() != 0) begin
                r = rets.pop_front();
                if (r.host) m_h_hold = r.data; else m_iic_hold = r.data;
            end
            if (iic_write) ref_mem[iic_address] = iic_writedata;
            else if (iic_read) rets.push_back('{1'b0, ref_mem[iic_address]});
            else if (!was_empty) begin
                q = pend.pop_front();
                if (q.we) ref_mem[q.addr] = q.wd;
                else rets.push_back('{1'b1, ref_mem[q.addr]});
            end
            if ((iic_write || iic_read) && !was_empty && m_cnt < 65535) m_cnt++;
            if (h_valid && was_empty) pend.push_back('{h_we, h_address, h_writedata});
        end
    endtask

    task automatic step(input bit do_chk);
        @(negedge clk);
        if (do_chk) model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, iw, ir; logic [7:0] ia, iwd;
        logic hv, hwe; logic [7:0] ha, hwd;
        logic chk_mem, mwe, mre; logic [7:0] ma, mwd;
        logic hr, hrv; logic [7:0] hrd, ird; logic [15:0] cnt;
    } vec_t;

    vec_t tbl [25];

    task automatic drive(input logic r, iw, ir, input logic [7:0] ia, iwd,
                         input logic hv, hwe, input logic [7:0] ha, hwd);
        rst = r; iic_write = iw; iic_read = ir; iic_address = ia; iic_writedata = iwd;
        h_valid = hv; h_we = hwe; h_address = ha; h_writedata = hwd;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        mem[8'h05] = 8'h6B; ref_mem[8'h05] = 8'h6B;

        //          rst iw ir ia     iwd    hv hwe ha     hwd    cm we re ma     mwd    hr rv hrd    ird    cnt
        tbl[0]  = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 16'd0};
        tbl[1]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'd0};
        tbl[2]  = '{0, 0, 1, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00, 16'd0};
        tbl[3]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'hA5, 16'd0};
        tbl[4]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'hA5, 16'd0};
        tbl[5]  = '{0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'hA5, 16'd0};
        tbl[6]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h20, 8'h3C, 0, 0, 8'h00, 8'hA5, 16'd0};
        tbl[7]  = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'hA5, 16'd0};
        tbl[8]  = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'hA5, 16'd0};
        tbl[9]  = '{0, 1, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h30, 8'h11, 0, 0, 8'h00, 8'hA5, 16'd0};
        tbl[10] = '{0, 1, 0, 8'h31, 8'h22, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h31, 8'h22, 0, 0, 8'h00, 8'hA5, 16'd1};
        tbl[11] = '{0, 1, 0, 8'h32, 8'h33, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h32, 8'h33, 0, 0, 8'h00, 8'hA5, 16'd2};
        tbl[12] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h05, 8'h00, 0, 0, 8'h00, 8'hA5, 16'd3};
        tbl[13] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 1, 8'h6B, 8'hA5, 16'd3};
        tbl[14] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h6B, 8'hA5, 16'd3};
        tbl[15] = '{0, 1, 1, 8'h10, 8'h77, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'h77, 1, 0, 8'h6B, 8'hA5, 16'd3};
        tbl[16] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h6B, 8'hA5, 16'd3};
        tbl[17] = '{0, 0, 1, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h00, 1, 0, 8'h6B, 8'hA5, 16'd3};
        tbl[18] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h6B, 8'h3C, 16'd3};
        tbl[19] = '{0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h6B, 8'h3C, 16'd3};
        tbl[20] = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h6B, 8'h3C, 16'd3};
        tbl[21] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'd0};
        tbl[22] = '{1, 0, 1, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 16'd0};
        tbl[23] = '{1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 16'd0};
        tbl[24] = '{0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'd0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0);
        step(0);

        for (int k = 0; k < 25; k++) begin
            drive(tbl[k].rst, tbl[k].iw, tbl[k].ir, tbl[k].ia, tbl[k].iwd,
                  tbl[k].hv, tbl[k].hwe, tbl[k].ha, tbl[k].hwd);
            @(negedge clk);
            if (tbl[k].chk_mem) begin
                check($sformatf("t%0d_mem_ctl", k), {mem_we, mem_re}, {tbl[k].mwe, tbl[k].mre});
                check($sformatf("t%0d_mem_addr", k), mem_address, tbl[k].ma);
                check($sformatf("t%0d_mem_wd", k), mem_writedata, tbl[k].mwd);
            end
            check($sformatf("t%0d_h_ready", k), h_ready, tbl[k].hr);
            check($sformatf("t%0d_h_rvalid", k), h_rvalid, tbl[k].hrv);
            check($sformatf("t%0d_h_readdata", k), h_readdata, tbl[k].hrd);
            check($sformatf("t%0d_iic_readdata", k), iic_readdata, tbl[k].ird);
            check($sformatf("t%0d_conflict_cnt", k), conflict_cnt, tbl[k].cnt);
            @(posedge clk);
            model_update();
            #1;
        end

        // Saturation: one buffered host read blocked by 70000 IIC writes.
        drive(0, 0, 0, 0, 0, 1, 0, 8'h05, 0);
        step(1);
        drive(0, 1, 0, 8'hF0, 8'h99, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) step(0);
        @(negedge clk);
        check("sat_cnt", conflict_cnt, 16'hFFFF);
        check("sat_blocked_ready", h_ready, 1'b0);
        @(posedge clk); model_update(); #1;
        step(1);
        @(negedge clk);
        check("sat_cnt_hold", conflict_cnt, 16'hFFFF);
        @(posedge clk); model_update(); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_issue_re", {mem_re, mem_address}, {1'b1, 8'h05});
        @(posedge clk); model_update(); #1;
        @(negedge clk);
        check("sat_rvalid", {h_rvalid, h_readdata}, {1'b1, 8'h6B});
        @(posedge clk); model_update(); #1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  8'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  8'($urandom_range(0, 15)), 8'($urandom));
            step(1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
